// File: rtl/bus_arbiter_rr_pkg.sv
// rtl/bus_arbiter_rr_pkg.sv - shared constants and helpers for the round-robin bus arbiter
package bus_arbiter_rr_pkg;

  // Active-low enable aliases from the global config; grants and requests are active-low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Width of the hold counter and its saturation value.
  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

  // Default configuration matching the previous fixed 4-master arbiter.
  localparam int DEFAULT_NUM_MASTERS = 4;
  localparam int DEFAULT_MAX_HOLD    = 16;

  // Saturating increment for the hold counter.
  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - circular first-requester search starting after the current owner
module bus_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] cur,
  output logic          found,
  output logic [OW-1:0] nxt
);

  // Index at circular distance ofs from base; ofs is always in 1..N-1.
  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N) s = s - N;
    return OW'(s);
  endfunction

  // Scan from the farthest distance down so the nearest requester is the last to write.
  // Distance 0 (the owner itself) is never examined, which masks the owner bit.
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int k = N - 1; k >= 1; k--) begin
      if (req[wrap_idx(cur, k)]) begin
        found = 1'b1;
        nxt   = wrap_idx(cur, k);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with hold-quantum preemption and owner lock
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
  parameter int OWNER_W     = 2,
  parameter int MAX_HOLD    = DEFAULT_MAX_HOLD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req_,
  input  logic [NUM_MASTERS-1:0] lock_,
  output logic [NUM_MASTERS-1:0] grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic [HOLD_W-1:0]      hold_cnt
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
    $error("bus_arbiter_rr: NUM_MASTERS must be within 2..16");
  end
  if (OWNER_W != $clog2(NUM_MASTERS)) begin : g_bad_owner_w
    $error("bus_arbiter_rr: OWNER_W must equal clog2(NUM_MASTERS)");
  end
  if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter_rr: MAX_HOLD must be within 0..255");
  end

  // The owner becomes preemptible once it has held the bus for MAX_HOLD cycles.
  localparam bit                PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] EXPIRE_AT  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [NUM_MASTERS-1:0] req;
  logic                   own_req;
  logic                   others;
  logic                   expired;
  logic                   locked;
  logic [OWNER_W-1:0]     pick_idx;
  logic [OWNER_W-1:0]     owner_nxt;
  logic [HOLD_W-1:0]      hold_nxt;

  assign req     = ~req_;
  assign own_req = req[owner];
  assign locked  = (lock_[owner] == ENABLE_);
  assign expired = PREEMPT_EN && (hold_cnt >= EXPIRE_AT);

  bus_arbiter_rr_pick #(
    .N  (NUM_MASTERS),
    .OW (OWNER_W)
  ) u_pick (
    .req   (req),
    .cur   (owner),
    .found (others),
    .nxt   (pick_idx)
  );

  // Next owner and hold count: keep a requesting owner unless its quantum is up and
  // someone else is waiting, otherwise hand over round-robin, otherwise park.
  always_comb begin
    owner_nxt = owner;
    hold_nxt  = '0;
    if (own_req && (!expired || locked || !others)) begin
      hold_nxt = hold_inc(hold_cnt);
    end else if (others) begin
      owner_nxt = pick_idx;
    end
  end

  // Owner and hold counter registers; reset parks master 0 on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Grant decode straight from the owner register so exactly one grant is low.
  always_comb begin
    grnt_        = {NUM_MASTERS{DISABLE_}};
    grnt_[owner] = ENABLE_;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_;
  logic [3:0] lock_;

  logic [3:0] grnt4_;
  logic [1:0] owner4;
  logic [7:0] hold4;
  logic [3:0] grnt0_;
  logic [1:0] owner0;
  logic [7:0] hold0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(4)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .req_     (req_),
    .lock_    (lock_),
    .grnt_    (grnt4_),
    .owner    (owner4),
    .hold_cnt (hold4)
  );

  bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(0)) u_dut0 (
    .clk      (clk),
    .reset    (reset),
    .req_     (req_),
    .lock_    (lock_),
    .grnt_    (grnt0_),
    .owner    (owner0),
    .hold_cnt (hold0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_  = 4'b1111;
    lock_ = 4'b1111;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_  = 4'b1111;
    lock_ = 4'b1111;
    reset = 1'b0;
    #2;
    checks++;
    if (owner4 !== 2'd0 || grnt4_ !== 4'b1110 || hold4 !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: owner=%0d grnt_=%b hold=%0d, want 0 1110 0", owner4, grnt4_, hold4);
    end
    checks++;
    if (owner0 !== 2'd0 || grnt0_ !== 4'b1110 || hold0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_state_nohold: owner=%0d grnt_=%b hold=%0d, want 0 1110 0", owner0, grnt0_, hold0);
    end
    #2;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (owner4 !== 2'd0 || grnt4_ !== 4'b1110 || hold4 !== 8'd0) begin
        errors++;
        $display("FAIL park cycle %0d: owner=%0d grnt_=%b hold=%0d, want 0 1110 0", i, owner4, grnt4_, hold4);
      end
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_owner;
    logic [7:0] exp_hold;
    logic [3:0] exp_grnt;
    do_reset();
    req_ = 4'b0000;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_owner = 2'(k / 4);
      exp_hold  = 8'(k % 4);
      exp_grnt  = 4'b0001 << exp_owner;
      exp_grnt  = ~exp_grnt;
      checks++;
      if (owner4 !== exp_owner || hold4 !== exp_hold || grnt4_ !== exp_grnt) begin
        errors++;
        $display("FAIL rotation edge %0d: owner=%0d hold=%0d grnt_=%b, want %0d %0d %b",
                 k, owner4, hold4, grnt4_, exp_owner, exp_hold, exp_grnt);
      end
    end
  endtask

  task automatic test_release_handoff();
    do_reset();
    req_ = 4'b1101;
    tick();
    req_ = 4'b0100;
    tick();
    tick();
    checks++;
    if (owner4 !== 2'd1 || hold4 !== 8'd2) begin
      errors++;
      $display("FAIL handoff_setup: owner=%0d hold=%0d, want 1 2", owner4, hold4);
    end
    req_ = 4'b0110;
    tick();
    checks++;
    if (owner4 !== 2'd3 || hold4 !== 8'd0 || grnt4_ !== 4'b0111) begin
      errors++;
      $display("FAIL handoff: owner=%0d hold=%0d grnt_=%b, want 3 0 0111", owner4, hold4, grnt4_);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_ = 4'b1110;
    tick();
    req_ = 4'b1001;
    tick();
    checks++;
    if (owner4 !== 2'd1) begin
      errors++;
      $display("FAIL simultaneous_from0: owner=%0d, want 1", owner4);
    end
    req_ = 4'b0111;
    tick();
    checks++;
    if (owner4 !== 2'd3) begin
      errors++;
      $display("FAIL simultaneous_setup: owner=%0d, want 3", owner4);
    end
    req_ = 4'b1001;
    tick();
    checks++;
    if (owner4 !== 2'd1 || hold4 !== 8'd0) begin
      errors++;
      $display("FAIL simultaneous_wrap: owner=%0d hold=%0d, want 1 0", owner4, hold4);
    end
  endtask

  task automatic test_lock();
    do_reset();
    req_ = 4'b1011;
    tick();
    lock_ = 4'b1011;
    req_  = 4'b0000;
    for (int i = 1; i <= 50; i++) begin
      tick();
      checks++;
      if (owner4 !== 2'd2 || hold4 !== 8'(i)) begin
        errors++;
        $display("FAIL lock cycle %0d: owner=%0d hold=%0d, want 2 %0d", i, owner4, hold4, i);
      end
    end
    lock_ = 4'b1111;
    tick();
    checks++;
    if (owner4 !== 2'd3 || hold4 !== 8'd0) begin
      errors++;
      $display("FAIL unlock: owner=%0d hold=%0d, want 3 0", owner4, hold4);
    end
  endtask

  task automatic test_no_preempt_wrap();
    do_reset();
    req_ = 4'b0111;
    tick();
    checks++;
    if (owner0 !== 2'd3 || hold0 !== 8'd0) begin
      errors++;
      $display("FAIL nopreempt_setup: owner=%0d hold=%0d, want 3 0", owner0, hold0);
    end
    req_ = 4'b0110;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (owner0 !== 2'd3) begin
        checks++;
        errors++;
        $display("FAIL nopreempt_owner cycle %0d: owner=%0d, want 3", i, owner0);
      end
      if (i == 100) begin
        checks++;
        if (hold0 !== 8'd100) begin
          errors++;
          $display("FAIL hold_count_100: hold=%0d, want 100", hold0);
        end
      end
    end
    checks++;
    if (owner0 !== 2'd3 || hold0 !== 8'd255) begin
      errors++;
      $display("FAIL hold_saturate: owner=%0d hold=%0d, want 3 255", owner0, hold0);
    end
    req_ = 4'b1110;
    tick();
    checks++;
    if (owner0 !== 2'd0 || hold0 !== 8'd0 || grnt0_ !== 4'b1110) begin
      errors++;
      $display("FAIL wrap_release: owner=%0d hold=%0d grnt_=%b, want 0 0 1110", owner0, hold0, grnt0_);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_ = 4'b1011;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (owner4 !== 2'd2 || hold4 !== 8'd7) begin
      errors++;
      $display("FAIL async_setup: owner=%0d hold=%0d, want 2 7", owner4, hold4);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (grnt4_ !== 4'b1110 || owner4 !== 2'd0 || hold4 !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: grnt_=%b owner=%0d hold=%0d, want 1110 0 0", grnt4_, owner4, hold4);
    end
    #1;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_release_handoff();
    test_simultaneous();
    test_lock();
    test_no_preempt_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
